// File: rtl/bcd_seq_adder_ctrl.sv
// Sequential packed-BCD adder controller: one two-digit BCD add slice per clock, LSB pair first,
// with valid/ready handshakes on the operand and result sides.
module bcd_seq_adder_ctrl #(
    parameter int unsigned DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err,
    output logic                  busy
);
    localparam int unsigned PAIRS = DIGITS / 2;
    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           carry_q;
    logic [IW-1:0]  idx_q;

    logic           bad_digit;
    logic [7:0]     pa;
    logic [7:0]     pb;
    logic [4:0]     lo;
    logic [4:0]     hi;
    logic [7:0]     pair_sum;
    logic           pair_carry;

    // Returns {carry, digit}; a raw sum of exactly 9 is left uncorrected.
    function automatic logic [4:0] bcd_digit(input logic [3:0] x, input logic [3:0] y,
                                             input logic c);
        logic [4:0] t;
        t = {1'b0, x} + {1'b0, y} + {4'b0, c};
        if (t > 5'd9) begin
            return {1'b1, 4'(t + 5'd6)};
        end
        return {1'b0, t[3:0]};
    endfunction

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        pa         = a_q[8*int'(idx_q) +: 8];
        pb         = b_q[8*int'(idx_q) +: 8];
        lo         = bcd_digit(pa[3:0], pb[3:0], carry_q);
        hi         = bcd_digit(pa[7:4], pb[7:4], lo[4]);
        pair_sum   = {hi[3:0], lo[3:0]};
        pair_carry = hi[4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        err     <= bad_digit;
                        state   <= bad_digit ? StDone : StCalc;
                    end
                end
                StCalc: begin
                    sum[8*int'(idx_q) +: 8] <= pair_sum;
                    carry_q                 <= pair_carry;
                    idx_q                   <= idx_q + 1'b1;
                    if (idx_q == IW'(PAIRS - 1)) begin
                        cout  <= pair_carry;
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);
    assign busy      = (state != StIdle);

endmodule

// File: tb/tb_bcd_seq_adder_ctrl.sv
// Randomized and directed bench for bcd_seq_adder_ctrl against a decimal-arithmetic reference.
module tb_bcd_seq_adder_ctrl;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned PAIRS  = DIGITS / 2;
    localparam int unsigned W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout;
    logic          err;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;

    bcd_seq_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: decode both operands to integers, add in decimal, re-encode.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] ms, output logic mco, output logic me);
        longint av = 0, bv = 0, lim = 1, t;
        me = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) me = 1'b1;
            av  = av * 10 + longint'(ma[4*i +: 4]);
            bv  = bv * 10 + longint'(mb[4*i +: 4]);
            lim = lim * 10;
        end
        ms  = '0;
        mco = 1'b0;
        if (!me) begin
            t   = av + bv + longint'(mc);
            mco = (t >= lim);
            t   = t % lim;
            for (int i = 0; i < int'(DIGITS); i++) begin
                ms[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands and returns just after the accepting edge; operand bus is then scrambled.
    task automatic accept_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        int guard = 0;
        in_valid = 1'b1;
        a = xa;
        b = xb;
        cin = xc;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check_eq("accept_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    // Latency is counted in edges including the accepting one.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                input logic xc);
        logic [W-1:0] es;
        logic eco, ee;
        model(xa, xb, xc, es, eco, ee);
        check_eq({tag, "_sum"}, 64'(sum), 64'(es));
        check_eq({tag, "_cout"}, 64'(cout), 64'(eco));
        check_eq({tag, "_err"}, 64'(err), 64'(ee));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc);
        logic [W-1:0] es;
        logic eco, ee;
        model(xa, xb, xc, es, eco, ee);
        accept_op(xa, xb, xc);
        wait_result(tag, ee ? 1 : PAIRS + 1);
        check_eq({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
        check_result(tag, xa, xb, xc);
        repeat ($urandom_range(0, 2)) tick();
        release_result(tag);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < int'(DIGITS); i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        logic [W-1:0] ra, rb, held_sum;
        logic held_cout, held_err;

        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_sum", 64'(sum), 64'd0);
        check_eq("rst_cout_err", 64'({cout, err}), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        run_op("t1_9p9p1", 32'h00000009, 32'h00000009, 1'b1);
        run_op("t2_ripple", 32'h99999999, 32'h00000000, 1'b1);
        run_op("t3_all9", 32'h12345678, 32'h87654321, 1'b0);
        run_op("t3_exact9", 32'h00000005, 32'h00000004, 1'b0);
        run_op("t4_badnib", 32'h0000000A, 32'h00000001, 1'b0);
        run_op("t4_badb", 32'h00000001, 32'hF0000000, 1'b1);

        // Stall in DONE while new operands are offered.
        accept_op(32'h00001234, 32'h00005678, 1'b0);
        wait_result("t5", PAIRS + 1);
        held_sum = sum;
        held_cout = cout;
        held_err = err;
        in_valid = 1'b1;
        a = 32'h00000111;
        b = 32'h00000222;
        cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t5_hold_valid", 64'(out_valid), 64'd1);
            check_eq("t5_hold_in_ready", 64'(in_ready), 64'd0);
            check_eq("t5_hold_sum", 64'({sum, cout, err}), 64'({held_sum, held_cout, held_err}));
        end
        check_result("t5_first", 32'h00001234, 32'h00005678, 1'b0);
        release_result("t5");
        accept_op(32'h00000111, 32'h00000222, 1'b1);
        check_eq("t5_busy_after_accept", 64'(busy), 64'd1);
        wait_result("t5_second", PAIRS + 1);
        check_result("t5_second", 32'h00000111, 32'h00000222, 1'b1);
        release_result("t5_second");

        // Asynchronous reset in the middle of the pair walk.
        accept_op(32'h12345678, 32'h11111111, 1'b1);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("t6_rst_busy", 64'(busy), 64'd0);
        check_eq("t6_rst_sum", 64'(sum), 64'd0);
        check_eq("t6_rst_cout_err", 64'({cout, err}), 64'd0);
        check_eq("t6_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("t6_fresh", 32'h00000001, 32'h00000001, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            // Early out_ready must not matter outside DONE.
            out_ready = 1'($urandom);
            run_op("rand", ra, rb, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
